i2s_tx_ctrl: RTL and testbench

Frame-level sequencer for the I2S transmit path. It buffers stereo samples from the audio source through a valid/ready FIFO and commits one left/right pair per LRCLK frame on the frame-start tick from the clock generator. It serializes the committed pair MSB-first onto SDATA using the generator's bit index, and detects and counts FIFO underruns. It sits between the sample producer and the I2S pins, driven entirely by the clock generator's tick/count outputs.

---
 rtl/i2s_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit sequencer: buffers stereo pairs, commits one pair per LRCLK frame, serializes MSB-first.
// Build macro I2S_TX_UNDERRUN_REPEAT_EN: on underrun hold the previous pair instead of sending silence.
module i2s_tx_ctrl #(
  parameter int DATA_BIT   = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk_12_288,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [DATA_BIT-1:0]           i_left,
  input  logic [DATA_BIT-1:0]           i_right,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic                          i_start,
  input  logic                          i_finish,
  input  logic [$clog2(DATA_BIT)-1:0]   i_count,
  input  logic                          i_count_valid,
  input  logic                          i_count_lrclk,
  output logic                          o_sdata,
  output logic                          o_underrun,
  output logic [7:0]                    o_underrun_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);
  localparam int CW = $clog2(DATA_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW:0]   BIT_LIMIT = (CW+1)'(DATA_BIT);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_BIT-1:0]   left_q, left_d;
  logic [DATA_BIT-1:0]   right_q, right_d;
  logic                  sdata_q, sdata_d;
  logic                  underrun_q, underrun_d;
  logic [7:0]            ucnt_q, ucnt_d;
  logic [DATA_BIT-1:0]   mem_left_q  [FIFO_DEPTH];
  logic [DATA_BIT-1:0]   mem_right_q [FIFO_DEPTH];

  logic full, empty, ready, push, pop, flush, starve;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  // Ready depends only on registered state, so a same-cycle pop never opens a slot.
  assign ready = ((state_q == S_ARM) || (state_q == S_RUN)) && !full;
  assign push  = i_valid && ready;

  always_ff @(posedge i_clk_12_288) begin
    if (push) begin
      mem_left_q[wr_ptr_q]  <= i_left;
      mem_right_q[wr_ptr_q] <= i_right;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    pop        = 1'b0;
    flush      = 1'b0;
    starve     = 1'b0;

    case (state_q)
      S_IDLE: if (i_enable) state_d = S_ARM;
      S_ARM: begin
        if (!i_enable) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end else if (i_start && !empty) begin
          pop     = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_start) begin
          if (!empty) pop = 1'b1;
          else        starve = 1'b1;
        end
        if (!i_enable) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // i_start wins over a coincident i_finish, so that cycle never ends the drain.
        if (i_enable) begin
          state_d = S_RUN;
        end else if (i_finish && !i_start) begin
          state_d = S_IDLE;
          flush   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      left_d   = mem_left_q[rd_ptr_q];
      right_d  = mem_right_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (starve) begin
      underrun_d = 1'b1;
      if (ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
      left_d  = left_q;
      right_d = right_q;
`else
      left_d  = '0;
      right_d = '0;
`endif
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      left_d   = '0;
      right_d  = '0;
    end

    sdata_d = 1'b0;
    if ((state_q != S_IDLE) && i_count_valid && ({1'b0, i_count} < BIT_LIMIT))
      sdata_d = i_count_lrclk ? left_q[i_count] : right_q[i_count];
  end

  always_ff @(posedge i_clk_12_288 or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      left_q     <= '0;
      right_q    <= '0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      left_q     <= left_d;
      right_q    <= right_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign o_ready        = ready;
  assign o_sdata        = sdata_q;
  assign o_underrun     = underrun_q;
  assign o_underrun_cnt = ucnt_q;
  assign o_level        = level_q;
endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Scoreboard bench for i2s_tx_ctrl: expected serial bits queued by the driver, compared by a monitor.
module tb_i2s_tx_ctrl;
  logic        clk = 1'b0;
  logic        i_reset, i_enable, i_valid, i_start, i_finish;
  logic [23:0] i_left, i_right;
  logic [4:0]  i_count;
  logic        i_count_valid, i_count_lrclk;
  logic        o_ready, o_sdata, o_underrun;
  logic [7:0]  o_underrun_cnt;
  logic [2:0]  o_level;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  logic bit_q[$];
  logic cv_d;

  localparam logic [23:0] P0L = 24'hA5A5A5, P0R = 24'h5A5A5A;
  localparam logic [23:0] P1L = 24'h123456, P1R = 24'hFEDCBA;
  localparam logic [23:0] P2L = 24'h800000, P2R = 24'h7FFFFF;
  localparam logic [23:0] P3L = 24'h000001, P3R = 24'hFFFFFE;
  localparam logic [23:0] P4L = 24'hC3C3C3, P4R = 24'h3C3C3C;
  localparam logic [23:0] P5L = 24'h0F0F0F, P5R = 24'hF0F0F0;
  localparam logic [23:0] P6L = 24'h800001, P6R = 24'h000000;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  localparam logic [23:0] UL = P3L, UR = P3R;
`else
  localparam logic [23:0] UL = 24'h0, UR = 24'h0;
`endif

  i2s_tx_ctrl #(.DATA_BIT(24), .FIFO_DEPTH(4)) dut (
    .i_clk_12_288(clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_left(i_left), .i_right(i_right), .i_valid(i_valid), .o_ready(o_ready),
    .i_start(i_start), .i_finish(i_finish), .i_count(i_count),
    .i_count_valid(i_count_valid), .i_count_lrclk(i_count_lrclk),
    .o_sdata(o_sdata), .o_underrun(o_underrun),
    .o_underrun_cnt(o_underrun_cnt), .o_level(o_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: a payload slot sampled at a rising edge produces one o_sdata bit visible at the next falling edge.
  always @(posedge clk or posedge i_reset) begin
    if (i_reset) cv_d <= 1'b0;
    else         cv_d <= i_count_valid;
  end

  always @(negedge clk) begin
    if (i_reset) begin
      bit_q.delete();
    end else begin
      if (o_underrun) pulses++;
      if (cv_d) begin
        if (bit_q.size() == 0) check("sdata_unexpected", 32'(o_sdata), 32'hFFFF_FFFF);
        else check("sdata_bit", 32'(o_sdata), 32'(bit_q.pop_front()));
      end
    end
  end

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    i_valid = 1'b1; i_left = l; i_right = r;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic short_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(posedge clk); #1;
  endtask

  // One frame: start tick, 24 left slots, 24 right slots, i_finish on the last right slot.
  task automatic frame(input logic [23:0] l, input logic [23:0] r, input logic exp_under,
                       input int drop_at, input logic vos);
    i_start = 1'b1; i_count_valid = 1'b0;
    i_valid = vos; i_left = 24'hDEAD00; i_right = 24'h00BEEF;
    @(posedge clk); #1;
    i_start = 1'b0; i_valid = 1'b0;
    check("underrun_pulse", 32'(o_underrun), 32'(exp_under));
    if (vos) begin
      check("level_after_full_start", 32'(o_level), 32'd3);
      check("ready_after_full_start", 32'(o_ready), 32'd1);
    end
    for (int k = 0; k < 48; k++) begin
      i_count_valid = 1'b1;
      i_count_lrclk = (k < 24);
      i_count       = 5'(23 - (k % 24));
      bit_q.push_back((k < 24) ? l[23-k] : r[47-k]);
      i_finish      = (k == 47);
      if (k == drop_at) i_enable = 1'b0;
      @(posedge clk); #1;
    end
    i_count_valid = 1'b0; i_finish = 1'b0; i_count_lrclk = 1'b0; i_count = 5'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_start = 1'b0; i_finish = 1'b0;
    i_left = '0; i_right = '0; i_count = '0; i_count_valid = 1'b0; i_count_lrclk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_sdata", 32'(o_sdata), 32'd0);
    check("rst_underrun", 32'(o_underrun), 32'd0);
    check("rst_cnt", 32'(o_underrun_cnt), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    i_reset = 1'b0;
    @(posedge clk); #1;
    check("idle_ready", 32'(o_ready), 32'd0);

    i_enable = 1'b1;
    @(posedge clk); #1;
    check("ready_after_enable", 32'(o_ready), 32'd1);

    // Frame tick in ARM with an empty FIFO is ignored and never counted.
    short_start();
    check("arm_no_underrun", 32'(o_underrun), 32'd0);
    check("arm_cnt", 32'(o_underrun_cnt), 32'd0);
    check("arm_pulses", 32'(pulses), 32'd0);

    push_pair(P0L, P0R);
    push_pair(P1L, P1R);
    push_pair(P2L, P2R);
    push_pair(P3L, P3R);
    check("level_full", 32'(o_level), 32'd4);
    check("ready_full", 32'(o_ready), 32'd0);
    push_pair(24'h111111, 24'h222222);
    check("level_drop_push", 32'(o_level), 32'd4);

    frame(P0L, P0R, 1'b0, -1, 1'b1);
    frame(P1L, P1R, 1'b0, -1, 1'b0);
    frame(P2L, P2R, 1'b0, -1, 1'b0);
    frame(P3L, P3R, 1'b0, -1, 1'b0);
    check("level_empty", 32'(o_level), 32'd0);

    for (int f = 0; f < 3; f++) frame(UL, UR, 1'b1, -1, 1'b0);
    check("cnt_3", 32'(o_underrun_cnt), 32'd3);
    check("pulses_3", 32'(pulses), 32'd3);

    for (int f = 0; f < 252; f++) short_start();
    check("cnt_255", 32'(o_underrun_cnt), 32'd255);
    for (int f = 0; f < 45; f++) short_start();
    check("cnt_sat", 32'(o_underrun_cnt), 32'd255);
    check("pulses_300", 32'(pulses), 32'd300);

    push_pair(P4L, P4R);
    push_pair(P5L, P5R);
    check("level_2", 32'(o_level), 32'd2);
    frame(P4L, P4R, 1'b0, 10, 1'b0);
    check("drain_level", 32'(o_level), 32'd0);
    check("drain_ready", 32'(o_ready), 32'd0);
    @(posedge clk); #1;
    check("idle_sdata", 32'(o_sdata), 32'd0);

    i_enable = 1'b1;
    @(posedge clk); #1;
    push_pair(P6L, P6R);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_count_valid = 1'b1; i_count_lrclk = 1'b1; i_count = 5'd23;
    repeat (3) begin
      bit_q.push_back(P6L[23]);
      @(posedge clk); #1;
    end
    check("pre_reset_sdata", 32'(o_sdata), 32'd1);
    #1 i_reset = 1'b1;
    #1;
    check("mid_rst_sdata", 32'(o_sdata), 32'd0);
    check("mid_rst_ready", 32'(o_ready), 32'd0);
    check("mid_rst_underrun", 32'(o_underrun), 32'd0);
    check("mid_rst_cnt", 32'(o_underrun_cnt), 32'd0);
    check("mid_rst_level", 32'(o_level), 32'd0);
    i_count_valid = 1'b0; i_enable = 1'b0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    @(posedge clk); #1;
    check("queue_drained", 32'(bit_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
